bit_diff_counter: RTL and testbench
===================================

BIT_DIFF_COUNTER -- requirements
Module: bit_diff_counter

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of valid bit pairs per frame, range 2..255.
REQ-002 Parameter CNT_W, default 4: width of diff_count, equal to ceil(log2(FRAME_LEN+1)).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  frame request, sampled only in IDLE.
REQ-006 Port valid  input  1  the current x/y bit pair is valid for counting.
REQ-007 Port x  input  1  serial operand A bit.
REQ-008 Port y  input  1  serial operand B bit.
REQ-009 Port busy  output  1  high in RUN and DONE.
REQ-010 Port done  output  1  one-cycle pulse, high while in DONE.
REQ-011 Port diff_count  output  CNT_W  number of positions where x differs from y in the last completed frame.
REQ-012 Port parity  output  1  XOR of all x^y bits in the last completed frame (diff_count[0]).
REQ-013 Port equal  output  1  high when the last completed frame had diff_count = 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL clear the accumulator and bit index and enter RUN; busy SHALL rise on that edge.
REQ-016 In RUN, each edge with valid=1 SHALL add (x^y) to the accumulator and increment the bit index; edges with valid=0 SHALL hold all state (stall).
REQ-017 The edge that accepts valid bit FRAME_LEN SHALL enter DONE, load diff_count, parity and equal from the final accumulated value, and raise done.
REQ-018 DONE SHALL last exactly one cycle, then return unconditionally to IDLE.
REQ-019 The latency from the last valid bit to done SHALL be zero cycles after that edge; done is visible in the cycle immediately following it.
REQ-020 diff_count, parity and equal SHALL hold their values until the next frame completes; they SHALL NOT change during RUN.
REQ-021 start SHALL be ignored in RUN and DONE; a frame begins only from IDLE.
REQ-022 x and y SHALL be ignored outside RUN or when valid=0.
REQ-023 The accumulator SHALL NOT wrap: its maximum value FRAME_LEN fits in CNT_W bits.
REQ-024 Bit order SHALL be bit 0 first; the count is order-independent.

Reset
REQ-025 On reset=1 at a rising edge, the FSM SHALL enter IDLE from any state, including mid-frame.
REQ-026 Reset SHALL clear busy, done, diff_count, parity, equal, the accumulator and the bit index to 0.
REQ-027 Reset SHALL take priority over start and valid in the same cycle.

Structure
REQ-028 The shared package SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default FRAME_LEN and CNT_W constants.
REQ-029 The per-bit difference SHALL be produced by one sub-module, xor_cell, built as a four-NAND gate network (output s, inputs a and b).
REQ-030 All other logic (FSM, counter, output registers) SHALL reside in bit_diff_counter.

Verification
REQ-031 x=8'b10110010, y=8'b10110010, valid always high -> done 8 edges after start is accepted; diff_count=0, equal=1, parity=0.
REQ-032 x=8'hFF, y=8'h00 -> diff_count=8, parity=0, equal=0; busy is high for 9 cycles.
REQ-033 x=8'hA5, y=8'h07, valid low for 3 cycles after bit 3 -> diff_count=3, parity=1; done arrives 3 cycles later than with no stall.
REQ-034 reset pulsed after 4 accepted bits of x=8'hFF, y=8'h00 -> all outputs 0 and FSM in IDLE on the next cycle; a following frame with x=8'h0F, y=8'h00 gives diff_count=4.
REQ-035 start held high continuously across two frames -> the second frame begins only in the IDLE cycle after DONE; done pulses exactly once per frame.

Source files
------------

// File: rtl/bit_diff_counter_pkg.sv
// Shared state encodings and default sizing for the serial bit-difference counter.
package bit_diff_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int FRAME_LEN_DEF = 8;
  localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/bit_diff_counter_xor_cell.sv
// xor_cell: one-bit difference a^b from four NAND gates; purely combinational.
module xor_cell (
  input  logic a,
  input  logic b,
  output logic s
);

  logic n_ab;
  logic n_a;
  logic n_b;

  assign n_ab = ~(a & b);
  assign n_a  = ~(a & n_ab);
  assign n_b  = ~(b & n_ab);
  assign s    = ~(n_a & n_b);

endmodule

// File: rtl/bit_diff_counter.sv
// Counts x/y bit differences over a FRAME_LEN-pair frame; done appears the cycle after the last valid bit.
// valid=0 stalls the frame indefinitely; start is only honoured while idle.
module bit_diff_counter
  import bit_diff_counter_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic             x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] diff_count,
  output logic             parity,
  output logic             equal
);

  localparam int IDX_W = 8;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_sum;
  logic [IDX_W-1:0] idx;
  logic             bit_diff;
  logic             accept;
  logic             last;
  logic             launch;

  xor_cell u_xor_cell (
    .a (x),
    .b (y),
    .s (bit_diff)
  );

  assign launch  = (state == ST_IDLE) && start;
  assign accept  = (state == ST_RUN) && valid;
  assign last    = accept && (idx == IDX_W'(FRAME_LEN - 1));
  // Sum of the bits seen so far including this one; never exceeds FRAME_LEN.
  assign acc_sum = acc + CNT_W'(bit_diff);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      idx        <= '0;
      diff_count <= '0;
      parity     <= 1'b0;
      equal      <= 1'b0;
    end else begin
      if (launch) begin
        acc <= '0;
        idx <= '0;
      end else if (accept) begin
        acc <= acc_sum;
        idx <= idx + IDX_W'(1);
      end
      // Results only move when a frame completes, so they stay stable through RUN.
      if (last) begin
        diff_count <= acc_sum;
        parity     <= acc_sum[0];
        equal      <= (acc_sum == '0);
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bit_diff_counter.sv
// Randomised self-checking bench for bit_diff_counter against a frame-level popcount model.
module tb_bit_diff_counter;

  localparam int FL = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          valid;
  logic          x;
  logic          y;
  logic          busy;
  logic          done;
  logic [CW-1:0] diff_count;
  logic          parity;
  logic          equal;

  int n_tests = 0;
  int n_fail  = 0;

  int prev_cnt = 0;
  int prev_par = 0;
  int prev_eq  = 0;

  bit_diff_counter #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .valid      (valid),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .diff_count (diff_count),
    .parity     (parity),
    .equal      (equal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_cnt"}, 32'(diff_count), prev_cnt);
    chk({tag, "_par"}, 32'(parity), prev_par);
    chk({tag, "_eq"},  32'(equal), prev_eq);
  endtask

  // One full frame: stall_len idle cycles inserted before bit stall_at, plus optional random stalls.
  task automatic run_frame(input string tag, input logic [FL-1:0] xv, input logic [FL-1:0] yv,
                           input int stall_at, input int stall_len, input bit rnd_stall,
                           output int latency, output int busy_cyc);
    int exp_cnt;
    int stalls;
    int ns;
    exp_cnt  = $countones(xv ^ yv);
    stalls   = 0;
    latency  = 0;
    busy_cyc = 0;
    start = 1'b1; valid = 1'b0; x = 1'($urandom); y = 1'($urandom);
    tick();
    busy_cyc += int'(busy);
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    for (int i = 0; i < FL; i++) begin
      ns = (i == stall_at) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < ns; s++) begin
        valid = 1'b0; x = 1'($urandom); y = 1'($urandom); start = 1'($urandom);
        tick();
        latency++; stalls++;
        busy_cyc += int'(busy);
        chk({tag, "_stall_done"}, 32'(done), 0);
        chk_held({tag, "_stall"});
      end
      valid = 1'b1; x = xv[i]; y = yv[i]; start = 1'($urandom);
      tick();
      latency++;
      busy_cyc += int'(busy);
      if (i < FL - 1) begin
        chk({tag, "_run_done"}, 32'(done), 0);
        chk_held({tag, "_run"});
      end
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_cnt"}, 32'(diff_count), exp_cnt);
    chk({tag, "_par"}, 32'(parity), exp_cnt % 2);
    chk({tag, "_eq"}, 32'(equal), (exp_cnt == 0) ? 1 : 0);
    chk({tag, "_lat"}, latency, FL + stalls);
    valid = 1'($urandom); start = 1'($urandom); x = 1'($urandom); y = 1'($urandom);
    tick();
    busy_cyc += int'(busy);
    chk({tag, "_done_fall"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    start = 1'b0; valid = 1'b0;
    prev_cnt = exp_cnt;
    prev_par = exp_cnt % 2;
    prev_eq  = (exp_cnt == 0) ? 1 : 0;
  endtask

  initial begin
    int lat;
    int bc;
    int done_n;
    int exp1;
    int exp2;
    logic xa [0:2*FL+3];
    logic ya [0:2*FL+3];

    // Reset asserted alongside start/valid must still win.
    reset = 1'b1; start = 1'b1; valid = 1'b1; x = 1'b1; y = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(diff_count), 0);
    chk("rst_par", 32'(parity), 0);
    chk("rst_eq", 32'(equal), 0);
    reset = 1'b0; start = 1'b0; valid = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    run_frame("same", 8'b10110010, 8'b10110010, -1, 0, 1'b0, lat, bc);
    chk("same_lat8", lat, 8);

    run_frame("ff00", 8'hFF, 8'h00, -1, 0, 1'b0, lat, bc);
    chk("ff00_busy9", bc, 9);

    run_frame("a507", 8'hA5, 8'h07, 4, 3, 1'b0, lat, bc);
    chk("a507_lat11", lat, 11);

    // Reset mid-frame after 4 accepted bits.
    start = 1'b1; valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; x = 1'b1; y = 1'b0;
      tick();
    end
    reset = 1'b1; start = 1'b1; valid = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_cnt", 32'(diff_count), 0);
    chk("mid_rst_par", 32'(parity), 0);
    chk("mid_rst_eq", 32'(equal), 0);
    reset = 1'b0; start = 1'b0; valid = 1'b0;
    prev_cnt = 0; prev_par = 0; prev_eq = 0;
    tick();
    chk("mid_rst_idle", 32'(busy), 0);
    run_frame("0f00", 8'h0F, 8'h00, -1, 0, 1'b0, lat, bc);

    // start held high across two back-to-back frames.
    done_n = 0;
    start = 1'b1; valid = 1'b1;
    exp1 = 0; exp2 = 0;
    for (int e = 0; e <= 2*FL+3; e++) begin
      xa[e] = 1'($urandom); ya[e] = 1'($urandom);
      x = xa[e]; y = ya[e];
      tick();
      if (e >= 1 && e <= FL) exp1 += int'(xa[e] ^ ya[e]);
      if (e >= FL+3 && e <= 2*FL+2) exp2 += int'(xa[e] ^ ya[e]);
      if (e == FL+1) chk("b2b_gap_idle", 32'(busy), 0);
      if (e == FL+2) chk("b2b_restart", 32'(busy), 1);
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          chk("b2b_d1_edge", e, FL);
          chk("b2b_d1_cnt", 32'(diff_count), exp1);
        end else begin
          chk("b2b_d2_edge", e, 2*FL+2);
          chk("b2b_d2_cnt", 32'(diff_count), exp2);
        end
      end
    end
    chk("b2b_done_pulses", done_n, 2);
    start = 1'b0; valid = 1'b0;
    tick();
    prev_cnt = exp2; prev_par = exp2 % 2; prev_eq = (exp2 == 0) ? 1 : 0;

    for (int f = 0; f < 30; f++) begin
      run_frame("rnd", FL'($urandom), FL'($urandom), -1, 0, 1'b1, lat, bc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
